// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 width codes, FSM states
// and the access-legality check used at request accept.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } lsu_state_t;

  // Stores have no unsigned forms, so BU/HU are illegal when write=1.
  function automatic logic access_err(input logic       write,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B, F3_BU: err = write && (funct3 == F3_BU);
      F3_H, F3_HU: err = addr_lo[0] || (write && (funct3 == F3_HU));
      F3_W:        err = (addr_lo != 2'b00);
      default:     err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: extracts and extends load data from a memory word, and
// merges sub-word store data into the word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;
  logic [3:0]  lane_en;
  logic [31:0] lane_data;

  assign shifted = word >> {addr_lo, 3'b000};

  always_comb begin
    load_data = shifted;
    lane_en   = 4'b1111;
    lane_data = wdata;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
    // Replicated store data lets each lane pick its own slice without a shifter.
    case (funct3[1:0])
      2'b00: begin
        lane_en   = 4'b0001 << addr_lo;
        lane_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign store_word[8*gi +: 8] = lane_en[gi] ? lane_data[8*gi +: 8] : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: RV32I byte/half/word accesses onto a
// word-wide memory, with read-modify-write for SB/SH and a held response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_dout
);

  lsu_state_t        state_reg, state_next;
  logic              write_reg;
  logic              err_reg;
  logic [2:0]        funct3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       buf_reg;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

  assign req_err  = access_err(req_write, req_funct3, req_addr[1:0]);
  assign mem_addr = {addr_reg[ADDR_W-1:2], 2'b00};

  lsu_align u_align (
    .funct3     (funct3_reg),
    .addr_lo    (addr_reg[1:0]),
    .word       (buf_reg),
    .wdata      (wdata_reg),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      write_reg  <= 1'b0;
      err_reg    <= 1'b0;
      funct3_reg <= 3'b000;
      addr_reg   <= '0;
      wdata_reg  <= 32'h0;
      buf_reg    <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        write_reg  <= req_write;
        err_reg    <= req_err;
        funct3_reg <= req_funct3;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
      end
      if (state_reg == RD) begin
        buf_reg <= mem_dout;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_din    = 32'h0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                             state_next = RESP;
          else if (req_write && req_funct3 == F3_W) state_next = WR;
          else                                     state_next = RD;
        end
      end
      RD: begin
        mem_read   = 1'b1;
        state_next = write_reg ? WR : RESP;
      end
      WR: begin
        // A reset arriving mid-write must not corrupt memory.
        mem_write  = !reset;
        mem_din    = store_word;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_reg;
        resp_rdata = (err_reg || write_reg) ? 32'h0 : load_data;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a bench-side memory and reference model
// predict rdata/err/latency/strobe counts for each access.
module tb_load_store_unit;

  localparam int ADDR_W = 32;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_dout;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  int          overlap = 0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] <= mem_din;
  end

  always @(negedge clk) begin
    if (mem_read)              rd_pulses <= rd_pulses + 1;
    if (mem_write)             wr_pulses <= wr_pulses + 1;
    if (mem_read && mem_write) overlap   <= overlap + 1;
  end

  // Reference model: byte-oriented view of the access, independent of the RTL lane logic.
  task automatic model_push(input bit wr, input bit [2:0] f3, input bit [7:0] a,
                            input bit [31:0] wd);
    exp_t        e;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int          sz;
    int          idx;
    int          sh;
    bit          bad;
    idx = int'(a[7:2]);
    sh  = 8 * int'(a[1:0]);
    w   = ref_mem[idx];
    sz  = int'(f3[1:0]);
    bad = (sz == 3) || (f3 == 3'b110) || (wr && f3[2]) ||
          (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    e.rdata = 32'h0;
    e.err   = bad;
    e.rd    = 0;
    e.wr    = 0;
    e.lat   = 1;
    if (!bad && !wr) begin
      e.lat = 2;
      e.rd  = 1;
      if (sz == 0) begin
        b = w[sh +: 8];
        e.rdata = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      end else if (sz == 1) begin
        h = a[1] ? w[31:16] : w[15:0];
        e.rdata = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      end else begin
        e.rdata = w;
      end
    end else if (!bad) begin
      e.wr = 1;
      if (sz == 2) begin
        e.lat = 2;
        ref_mem[idx] = wd;
      end else begin
        e.lat = 3;
        e.rd  = 1;
        if (sz == 0)   w[sh +: 8] = wd[7:0];
        else if (a[1]) w[31:16]   = wd[15:0];
        else           w[15:0]    = wd[15:0];
        ref_mem[idx] = w;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    @(negedge clk);
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // One full access: issue, wait for response, optionally stall it, then consume.
  task automatic access(input string name, input bit wr, input bit [2:0] f3,
                        input bit [7:0] a, input bit [31:0] wd, input int hold);
    exp_t e;
    int   lat;
    int   rd0;
    int   wr0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready_idle got %b want 1", name, req_ready);
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = {24'h0, a};
    req_wdata  = wd;
    model_push(wr, f3, a, wd);
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(lat);
    e = sb_q.pop_front();
    checks += 3;
    if (resp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s rdata got %h want %h", name, resp_rdata, e.rdata);
    end
    if (resp_err !== e.err) begin
      errors++;
      $display("FAIL %s err got %b want %b", name, resp_err, e.err);
    end
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, e.lat);
    end
    for (int i = 0; i < hold; i++) begin
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err ||
          req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d valid=%b rdata=%h ready=%b want 1/%h/0",
                 name, i, resp_valid, resp_rdata, req_ready, e.rdata);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    checks += 2;
    if (rd_pulses - rd0 !== e.rd) begin
      errors++;
      $display("FAIL %s mem_read_cycles got %0d want %0d", name, rd_pulses - rd0, e.rd);
    end
    if (wr_pulses - wr0 !== e.wr) begin
      errors++;
      $display("FAIL %s mem_write_cycles got %0d want %0d", name, wr_pulses - wr0, e.wr);
    end
    $display("txn %s wr=%0d f3=%b addr=%h rdata=%h err=%b lat=%0d", name, wr, f3, a,
             e.rdata, e.err, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks += 4;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake ready=%b valid=%b want 1/0", req_ready, resp_valid);
    end
    if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp rdata=%h err=%b want 0/0", resp_rdata, resp_err);
    end
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes rd=%b wr=%b want 0/0", mem_read, mem_write);
    end
    if (mem_addr !== 32'h0 || mem_din !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem_bus addr=%h din=%h want 0/0", mem_addr, mem_din);
    end
  endtask

  task automatic test_loads();
    access("LB_81",  1'b0, 3'b000, 8'h81, 32'h0, 0);
    access("LHU_82", 1'b0, 3'b101, 8'h82, 32'h0, 0);
    access("LH_82",  1'b0, 3'b001, 8'h82, 32'h0, 0);
    access("LBU_80", 1'b0, 3'b100, 8'h80, 32'h0, 0);
  endtask

  task automatic test_sub_word_store();
    access("SB_83", 1'b1, 3'b000, 8'h83, 32'h0000_0012, 0);
    checks++;
    if (mem[32] !== 32'h1299AABB) begin
      errors++;
      $display("FAIL sb_mem_word got %h want 1299aabb", mem[32]);
    end
    access("LW_80", 1'b0, 3'b010, 8'h80, 32'h0, 0);
    access("SH_42", 1'b1, 3'b001, 8'h42, 32'hFFFF_5A5A, 0);
  endtask

  task automatic test_errors();
    access("LW_86",  1'b0, 3'b010, 8'h86, 32'h0, 0);
    access("LH_81",  1'b0, 3'b001, 8'h81, 32'h0, 0);
    access("SH_41",  1'b1, 3'b001, 8'h41, 32'hCAFE, 0);
    access("SBU_40", 1'b1, 3'b100, 8'h40, 32'h11, 0);
    access("L111",   1'b0, 3'b111, 8'h40, 32'h0, 0);
  endtask

  task automatic test_reset_during_write();
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    req_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL sw_reset_in_wr mem_write got %b want 1", mem_write);
    end
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks += 2;
    if (mem[16] !== ref_mem[16]) begin
      errors++;
      $display("FAIL sw_reset_mem got %h want %h", mem[16], ref_mem[16]);
    end
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_reset_state ready=%b valid=%b want 1/0", req_ready, resp_valid);
    end
    $display("txn SW_40_reset mem40=%h", mem[16]);
  endtask

  task automatic test_backpressure();
    access("LW_80_hold", 1'b0, 3'b010, 8'h80, 32'h0, 5);
  endtask

  task automatic test_back_to_back();
    bit [2:0] f3s [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b001, 3'b111};
    bit [7:0] a;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 1) != 0) a[1] = 1'b0;
      access("rand", 1'($urandom_range(0, 1)), f3s[$urandom_range(0, 7)], a, $urandom, 0);
    end
    checks++;
    for (int i = 0; i < 64; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        errors++;
        $display("FAIL final_mem word %0d got %h want %h", i, mem[i], ref_mem[i]);
        break;
      end
    end
  endtask

  initial begin
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    reset      = 1'b1;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[32] = 32'h8899AABB;
    ref_mem[32] = 32'h8899AABB;
    mem[16] = 32'h01234567;
    ref_mem[16] = 32'h01234567;

    test_reset();
    test_loads();
    test_sub_word_store();
    test_errors();
    test_reset_during_write();
    test_backpressure();
    test_back_to_back();

    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL strobe_overlap got %0d cycles want 0", overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
